// File: rtl/divisor_sequencial.sv
// Iterative unsigned restoring divider (DIVU/REMU) for the ULA datapath.
// One trial subtraction per cycle through the adder/subtractor, start/done handshake.
module divisor_sequencial #(
   parameter int unsigned BITS = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [BITS-1:0] dividendo,
   input  logic [BITS-1:0] divisor,
   output logic            ocupado,
   output logic            pronto,
   output logic [BITS-1:0] quociente,
   output logic [BITS-1:0] resto
);

   localparam int unsigned CntW = $clog2(BITS) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(BITS - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e          state_q, state_d;
   logic [BITS:0]   rem_q, rem_d;
   logic [BITS-1:0] dvd_q, dvd_d;
   logic [BITS-1:0] dsr_q, dsr_d;
   logic [BITS-1:0] quo_q, quo_d;
   logic [BITS-1:0] res_q, res_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Adder/subtractor shared with the ULA, held in subtracting mode: a + ~b + 1
   logic            sub_mode;
   logic [BITS:0]   sub_a, sub_b, sub_sum;
   logic            sub_cout;

   logic [BITS:0]   rem_sh;
   logic            q_bit;

   assign sub_mode = 1'b1;
   assign rem_sh   = {rem_q[BITS-1:0], dvd_q[BITS-1]};
   assign sub_a    = rem_sh;
   assign sub_b    = {1'b0, dsr_q};

   assign {sub_cout, sub_sum} = {1'b0, sub_a}
                              + {1'b0, sub_b ^ {(BITS+1){sub_mode}}}
                              + {{(BITS+1){1'b0}}, sub_mode};

   // A set top bit before the shift means the shifted value exceeds any divisor
   assign q_bit = sub_cout | rem_q[BITS];

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      quo_d   = quo_q;
      res_d   = res_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (start) begin
               dvd_d = dividendo;
               dsr_d = divisor;
               rem_d = '0;
               cnt_d = '0;
               if (divisor == '0) begin
                  // RISC-V divide by zero: all-ones quotient, remainder is the dividend
                  state_d = StDone;
                  quo_d   = '1;
                  res_d   = dividendo;
               end else begin
                  state_d = StCalc;
               end
            end
         end

         StCalc: begin
            dvd_d = {dvd_q[BITS-2:0], q_bit};
            rem_d = q_bit ? sub_sum : rem_sh;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               state_d = StDone;
               quo_d   = {dvd_q[BITS-2:0], q_bit};
               res_d   = q_bit ? sub_sum[BITS-1:0] : rem_sh[BITS-1:0];
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ocupado   = (state_q == StCalc);
   assign pronto    = (state_q == StDone);
   assign quociente = quo_q;
   assign resto     = res_q;

endmodule
